note_player: RTL

- Consumer end of the note interface driven by the pattern sequencer.
- Generates the tick timebase and issues one-cycle note requests (o_note_stb).
- Accepts returned notes (valid/pitch/len/instrument), converts pitch to a 16-bit phase increment for the oscillator, and holds gate for the note's duration in ticks.
- Sits between the pattern sequencer and one oscillator/envelope channel.

---
 rtl/note_player_if.sv | 24 ++
 rtl/note_player.sv | 133 +++++++++++++
 2 files changed

// File: rtl/note_player_if.sv
// rtl/note_player_if.sv - note request/response handshake between sequencer and note player
interface note_player_if;
    logic       o_note_stb;
    logic       i_note_valid;
    logic [5:0] i_note_pitch;
    logic [4:0] i_note_len;
    logic [3:0] i_note_instrument;

    modport master (
        input  o_note_stb,
        output i_note_valid,
        output i_note_pitch,
        output i_note_len,
        output i_note_instrument
    );

    modport slave (
        output o_note_stb,
        input  i_note_valid,
        input  i_note_pitch,
        input  i_note_len,
        input  i_note_instrument
    );
endinterface

// File: rtl/note_player.sv
// rtl/note_player.sv - tick timebase, note requests, pitch-to-phase conversion and gate timing
// Optional macro NOTE_PLAYER_PROTOCOL_CHECK_EN adds sticky o_protocol_err.
module note_player #(
    parameter int TICK_DIV = 800,
    parameter int TICK_W   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    output logic        o_tick,
    note_player_if.slave note,
    output logic [15:0] o_phase_inc,
    output logic        o_gate,
`ifdef NOTE_PLAYER_PROTOCOL_CHECK_EN
    output logic        o_protocol_err,
`endif
    output logic [3:0]  o_instrument
);
    typedef enum logic [1:0] {IDLE, WAIT_NOTE, CONVERT, PLAY} state_t;

    state_t              r_state;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [5:0]          r_remaining;
    logic [5:0]          r_work;
    logic [2:0]          r_oct;
    logic [15:0]         r_phase_inc;
    logic                r_gate;
    logic [3:0]          r_instrument;
    logic                w_tick;
    logic                w_play_end;
    logic [15:0]         w_base;

    always_comb begin
        case (r_work[3:0])
            4'd0:    w_base = 16'd2858;
            4'd1:    w_base = 16'd3028;
            4'd2:    w_base = 16'd3208;
            4'd3:    w_base = 16'd3398;
            4'd4:    w_base = 16'd3600;
            4'd5:    w_base = 16'd3815;
            4'd6:    w_base = 16'd4041;
            4'd7:    w_base = 16'd4282;
            4'd8:    w_base = 16'd4536;
            4'd9:    w_base = 16'd4806;
            4'd10:   w_base = 16'd5092;
            default: w_base = 16'd5395;
        endcase
    end

    assign w_tick          = i_enable && !i_rst && (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_play_end      = w_tick && (r_state == PLAY) && (r_remaining == 6'd1);
    assign o_tick          = w_tick;
    assign note.o_note_stb = (w_tick && (r_state == IDLE)) || w_play_end;
    // Gate drops in the same cycle as the closing strobe, and is muted while disabled.
    assign o_gate          = r_gate && i_enable && !w_play_end;
    assign o_phase_inc     = r_phase_inc;
    assign o_instrument    = r_instrument;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_remaining  <= '0;
            r_work       <= '0;
            r_oct        <= '0;
            r_phase_inc  <= '0;
            r_gate       <= 1'b0;
            r_instrument <= '0;
        end else begin
            if (!i_enable || w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + 1'b1;

            if (i_enable) begin
                case (r_state)
                    IDLE: begin
                        if (w_tick)
                            r_state <= WAIT_NOTE;
                    end
                    WAIT_NOTE: begin
                        if (note.i_note_valid) begin
                            r_instrument <= note.i_note_instrument;
                            r_remaining  <= {1'b0, note.i_note_len} + 6'd1;
                            if (note.i_note_pitch == 6'd0) begin
                                r_phase_inc <= '0;
                                r_gate      <= 1'b0;
                                r_state     <= PLAY;
                            end else begin
                                r_work  <= note.i_note_pitch - 6'd1;
                                r_oct   <= '0;
                                r_state <= CONVERT;
                            end
                        end
                    end
                    CONVERT: begin
                        if (w_tick && r_remaining > 6'd1)
                            r_remaining <= r_remaining - 6'd1;
                        // Repeated subtraction: at most five octave steps for pitch 63.
                        if (r_work >= 6'd12) begin
                            r_work <= r_work - 6'd12;
                            r_oct  <= r_oct + 3'd1;
                        end else begin
                            r_phase_inc <= w_base >> (3'd5 - r_oct);
                            r_gate      <= 1'b1;
                            r_state     <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (w_tick) begin
                            if (r_remaining == 6'd1) begin
                                r_gate  <= 1'b0;
                                r_state <= WAIT_NOTE;
                            end else begin
                                r_remaining <= r_remaining - 6'd1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef NOTE_PLAYER_PROTOCOL_CHECK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_protocol_err <= 1'b0;
        else if ((note.i_note_valid && r_state != WAIT_NOTE) || (w_tick && r_state == CONVERT))
            o_protocol_err <= 1'b1;
    end
`endif
endmodule
